// File: rtl/add4_acc_ctl.sv
// Sequencer that accumulates NSAMP operands through an external 4-bit adder and hands out the total.
// Build option: define ADD4_ACC_SAT_EN to saturate the accumulator at 4'hF on carry-out instead of wrapping.
module add4_acc_ctl #(
    parameter int unsigned NSAMP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] opa,
    output logic [3:0] opb,
    input  logic [3:0] sum,
    input  logic       c4,
    output logic [3:0] res,
    output logic       res_ovf,
    output logic       res_valid,
    input  logic       res_ready
);

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSAMP);
    localparam logic [DW-1:0] ACC_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic [DW-1:0] acc_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          ovf_nxt;

    // Values captured from the adder at the end of SETTLE
    always_comb begin
        ovf_nxt = ovf | c4;
        cnt_nxt = cnt + CW'(1);
`ifdef ADD4_ACC_SAT_EN
        acc_nxt = ovf_nxt ? ACC_MAX : sum;
`else
        acc_nxt = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            in_ready  <= 1'b1;
            res       <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa      <= acc;
                        opb      <= in_data;
                        in_ready <= 1'b0;
                        state    <= SETTLE;
                    end
                end
                // Adder inputs have been stable for a full cycle; take its result
                SETTLE: begin
                    acc <= acc_nxt;
                    ovf <= ovf_nxt;
                    cnt <= cnt_nxt;
                    if (cnt_nxt == CNT_LAST) begin
                        state     <= DONE;
                        res       <= acc_nxt;
                        res_ovf   <= ovf_nxt;
                        res_valid <= 1'b1;
                        in_ready  <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        opa       <= '0;
                        opb       <= '0;
                        res       <= '0;
                        res_ovf   <= 1'b0;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/add4_acc_ctl.md
ADD4_ACC_CTL -- requirements
Module: add4_acc_ctl

Interface
REQ-001 SHALL have parameter NSAMP, default 4, number of operands summed per result (legal 1..15).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port in_data, input, 4, operand to accumulate.
REQ-005 SHALL have port in_valid, input, 1, in_data valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept in_data.
REQ-007 SHALL have port opa, output, 4, registered operand A to the 4-bit adder (A3..A0).
REQ-008 SHALL have port opb, output, 4, registered operand B to the 4-bit adder (B3..B0).
REQ-009 SHALL have port sum, input, 4, adder result (out3..out0).
REQ-010 SHALL have port c4, input, 1, adder carry-out.
REQ-011 SHALL have port res, output, 4, accumulated result.
REQ-012 SHALL have port res_ovf, output, 1, overflow occurred during this accumulation.
REQ-013 SHALL have port res_valid, output, 1, res/res_ovf valid.
REQ-014 SHALL have port res_ready, input, 1, consumer accepts res.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1, SHALL load opa<=acc, opb<=in_data, go to SETTLE.
REQ-017 SETTLE: in_ready=0; exactly one cycle; at its end SHALL capture acc<=sum, ovf<=ovf|c4, cnt<=cnt+1.
REQ-018 After capture, SHALL go to DONE if new cnt==NSAMP, else IDLE.
REQ-019 Per-operand throughput SHALL be one operand per 2 cycles max; in_valid low in IDLE holds all state.
REQ-020 DONE: res_valid=1, res=acc, res_ovf=ovf, in_ready=0; held stable until res_ready=1.
REQ-021 On DONE with res_ready=1, SHALL clear acc, ovf, cnt, opa, opb to 0 and go to IDLE next cycle; no operand accepted in that cycle.
REQ-022 res SHALL read 0 and res_valid 0 outside DONE.
REQ-023 Wrap-around: without saturation, acc SHALL take sum modulo 16 (c4 discarded except into ovf).
REQ-024 cnt SHALL be 4 bits, counting captured operands, never exceeding NSAMP.
REQ-025 in_valid asserted in SETTLE or DONE SHALL be ignored (not consumed).

Reset
REQ-026 rst=1 at a rising edge SHALL force state IDLE, acc=0, ovf=0, cnt=0, opa=0, opb=0, res_valid=0.
REQ-027 rst SHALL take priority over any handshake in the same cycle, including mid-SETTLE and DONE; partial accumulation is discarded.
REQ-028 First cycle after rst deassert SHALL have in_ready=1.

Configuration
REQ-029 Macro ADD4_ACC_SAT_EN defined: on capture with c4=1, acc SHALL be 4'hF and stay saturated for remaining operands (ovf also set).
REQ-030 Macro ADD4_ACC_SAT_EN undefined: acc wraps per REQ-023; ports unchanged.

Verification
REQ-031 NSAMP=4, operands 1,2,3,4 back-to-back in_valid -> res_valid after 8 cycles from first accept, res=10, res_ovf=0.
REQ-032 NSAMP=4, operands 8,8,1,0, no SAT -> res=1, res_ovf=1; with ADD4_ACC_SAT_EN -> res=15, res_ovf=1.
REQ-033 DONE with res_ready=0 for 5 cycles, in_valid=1 with in_data=7 -> res/res_valid stable, in_ready=0, 7 not consumed; res_ready=1 -> IDLE next cycle, acc=0.
REQ-034 rst pulse in SETTLE after 2 operands -> next cycle IDLE, in_ready=1; fresh 4 operands 5,5,5,0 -> res=15, res_ovf=0.
REQ-035 in_valid gaps (1 cycle on, 3 off) with operands 3,3,3,3 -> res=12; opa/opb observed as (0,3),(3,3),(6,3),(9,3).
